hazard_ctrl_pipe: RTL and testbench
===================================

Name: hazard_ctrl_pipe

Overview:
Parametrised ID/EX control-bundle pipeline register with integrated hazard handling. It replaces the combinational bubble mux with a registered stage. It detects load-use hazards and multi-cycle Hi/Lo (mult/div) occupancy, then inserts bubbles and gates PC/IF-ID writes. It sits between the decoder/control unit and the EX stage of the pipelined CPU and also accepts a branch flush.

Parameters:
WB_W, 2, width of WB control bundle {MemToReg, RegWrite}
M_W, 2, width of MEM control bundle {MemRead, MemWrite}
EX_W, 14, width of EX control bundle {RegDst, AluOp, AluSrc, AluMux, HiLoEnable}
MEMREAD_BIT, 1, bit index of MemRead inside the M bundle
REG_AW, 5, register-address width
MD_LAT, 4, mult/div occupancy in cycles (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_wb  input  WB_W  decoded WB controls
id_m  input  M_W  decoded MEM controls
id_ex  input  EX_W  decoded EX controls
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_AW  ID source reg rs
id_rt  input  REG_AW  ID source/dest reg rt
id_uses_rt  input  1  ID instruction reads rt
id_is_md  input  1  ID instruction is mult/div (writes Hi/Lo)
id_uses_hilo  input  1  ID instruction reads Hi/Lo (mfhi/mflo)
ex_flush  input  1  squash the instruction in ID (branch taken)
ex_wb  output  WB_W  registered WB controls
ex_m  output  M_W  registered MEM controls
ex_ex  output  EX_W  registered EX controls
ex_rt  output  REG_AW  registered rt
ex_valid  output  1  EX holds a real instruction
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register update enable
stall  output  1  hazard stall this cycle
md_busy  output  1  mult/div unit occupied

Behaviour:
- Reset (async, active-high): ex_wb, ex_m, ex_ex, ex_rt = 0; ex_valid = 0; counter = 0; state = IDLE. While reset is asserted, stall = 0, pc_write = 1, ifid_write = 1, md_busy = 0.
- lu_haz (combinational) = ex_valid & ex_m[MEMREAD_BIT] & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- md_haz (combinational) = md_busy & id_valid & (id_is_md | id_uses_hilo).
- stall = (lu_haz | md_haz) & ~ex_flush.
- pc_write = ifid_write = ~stall.
- Each rising edge, if stall or ex_flush or ~id_valid: load a bubble. The bubble is ex_wb, ex_m, ex_ex = 0; ex_rt = 0; ex_valid = 0.
- Otherwise: load id_* bundles and id_rt, and set ex_valid = 1.
- Latency: one cycle from ID inputs to ex_* outputs. A load-use stall lasts exactly 1 cycle, because the bubble clears lu_haz.
- ex_flush has priority over both hazards: the bubble is inserted and stall is forced to 0 so the fetch redirect proceeds.
- Mult/div FSM, IDLE -> BUSY: when a non-stalled, non-flushed id_is_md instruction is loaded, counter is set to MD_LAT-1. If MD_LAT == 1, the FSM stays IDLE.
- BUSY: counter decrements every cycle. At counter == 1 with decrement, go to IDLE and counter = 0.
- A new md op cannot enter while BUSY (md_haz stalls it). md_busy = (state == BUSY).
- The counter keeps running through flushes and stalls. A flush does not cancel an md op already issued.
- The md op itself is issued on the cycle it loads into EX. A dependent instruction in the next cycle stalls MD_LAT-1 cycles.
- Simultaneous lu_haz and md_haz: a single stall signal; each hazard resolves independently.
- Reset mid-operation: all state clears immediately (async) with no partial bubble.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds output stall_cycles [15:0], which increments on every cycle with stall = 1 and saturates at 16'hFFFF. It also adds output flush_count [15:0], which increments on every ex_flush and saturates at 16'hFFFF. Both clear to 0 on reset.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Reset release with id_valid = 0 -> ex_valid = 0, all ex_* = 0, pc_write = 1, stall = 0, md_busy = 0.
- lw $5 into EX (ex_m = 2'b10, ex_rt = 5), ID add with rs = 5 -> stall = 1 and pc_write = 0 for 1 cycle; next cycle ex_valid = 0 and ex_m = 0; the cycle after, the add loads normally. Repeat with rt = 0 -> no stall.
- lw $5 in EX, ID reads rt = 5 with id_uses_rt = 0 -> no stall; same with id_uses_rt = 1 -> 1-cycle stall.
- MD_LAT = 4: mult issued, then mfhi in ID next cycle -> stall for 3 cycles, md_busy high for 3 cycles; mfhi enters EX on the 4th cycle after the mult.
- Load-use condition plus ex_flush = 1 in the same cycle -> stall = 0, pc_write = 1, bubble loaded (ex_valid = 0).
- Reset asserted while BUSY with counter = 2 -> md_busy = 0 and ex_valid = 0 immediately; with HAZARD_STATS_EN, stall_cycles = 0.

Source files
------------

// File: rtl/hazard_ctrl_pipe.sv
// ID/EX control-bundle pipeline register with load-use and mult/div (Hi/Lo) hazard handling.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cycles and flush_count outputs.
module hazard_ctrl_pipe #(
    parameter int WB_W        = 2,
    parameter int M_W         = 2,
    parameter int EX_W        = 14,
    parameter int MEMREAD_BIT = 1,
    parameter int REG_AW      = 5,
    parameter int MD_LAT      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic [EX_W-1:0]   id_ex,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_md,
    input  logic              id_uses_hilo,
    input  logic              ex_flush,
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic [EX_W-1:0]   ex_ex,
    output logic [REG_AW-1:0] ex_rt,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              stall,
    output logic              md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A load in EX whose destination is a non-zero register read by the ID instruction.
    function automatic logic lu_hazard(
        input logic              ex_vld,
        input logic              ex_memread,
        input logic [REG_AW-1:0] ex_dst,
        input logic              id_vld,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              uses_rt
    );
        logic rs_match;
        logic rt_match;
        rs_match  = (ex_dst == rs);
        rt_match  = uses_rt & (ex_dst == rt);
        lu_hazard = ex_vld & ex_memread & (ex_dst != {REG_AW{1'b0}}) & id_vld & (rs_match | rt_match);
    endfunction

    logic [WB_W-1:0]   ex_wb_q,  ex_wb_d;
    logic [M_W-1:0]    ex_m_q,   ex_m_d;
    logic [EX_W-1:0]   ex_ex_q,  ex_ex_d;
    logic [REG_AW-1:0] ex_rt_q,  ex_rt_d;
    logic              ex_valid_q, ex_valid_d;
    md_state_t         state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic lu_haz_s;
    logic md_haz_s;
    logic stall_s;
    logic bubble_s;
    logic md_issue_s;

    // Hazard detection and stall/enable generation; a flush always wins over a stall.
    always_comb begin
        lu_haz_s   = lu_hazard(ex_valid_q, ex_m_q[MEMREAD_BIT], ex_rt_q,
                               id_valid, id_rs, id_rt, id_uses_rt);
        md_haz_s   = (state_q == MD_BUSY) & id_valid & (id_is_md | id_uses_hilo);
        stall_s    = (lu_haz_s | md_haz_s) & ~ex_flush;
        bubble_s   = stall_s | ex_flush | ~id_valid;
        md_issue_s = ~bubble_s & id_is_md;
    end

    // Next contents of the ID/EX register: bubble or the decoded ID bundle.
    always_comb begin
        ex_wb_d    = {WB_W{1'b0}};
        ex_m_d     = {M_W{1'b0}};
        ex_ex_d    = {EX_W{1'b0}};
        ex_rt_d    = {REG_AW{1'b0}};
        ex_valid_d = 1'b0;
        if (bubble_s) begin
            ex_wb_d    = {WB_W{1'b0}};
            ex_m_d     = {M_W{1'b0}};
            ex_ex_d    = {EX_W{1'b0}};
            ex_rt_d    = {REG_AW{1'b0}};
            ex_valid_d = 1'b0;
        end else begin
            ex_wb_d    = id_wb;
            ex_m_d     = id_m;
            ex_ex_d    = id_ex;
            ex_rt_d    = id_rt;
            ex_valid_d = 1'b1;
        end
    end

    // Mult/div occupancy FSM; the counter keeps running through stalls and flushes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_issue_s && (MD_LAT > 1)) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = MD_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            MD_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = MD_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = MD_BUSY;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // ID/EX register and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_wb_q    <= {WB_W{1'b0}};
            ex_m_q     <= {M_W{1'b0}};
            ex_ex_q    <= {EX_W{1'b0}};
            ex_rt_q    <= {REG_AW{1'b0}};
            ex_valid_q <= 1'b0;
            state_q    <= MD_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            ex_wb_q    <= ex_wb_d;
            ex_m_q     <= ex_m_d;
            ex_ex_q    <= ex_ex_d;
            ex_rt_q    <= ex_rt_d;
            ex_valid_q <= ex_valid_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_wb      = ex_wb_q;
    assign ex_m       = ex_m_q;
    assign ex_ex      = ex_ex_q;
    assign ex_rt      = ex_rt_q;
    assign ex_valid   = ex_valid_q;
    assign stall      = stall_s;
    assign pc_write   = ~stall_s;
    assign ifid_write = ~stall_s;
    assign md_busy    = (state_q == MD_BUSY);

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q,  flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_s && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (ex_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Self-checking bench for hazard_ctrl_pipe: scoreboard of expected ID/EX contents plus inline hazard checks.
module tb_hazard_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  id_wb;
    logic [1:0]  id_m;
    logic [13:0] id_ex;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_is_md;
    logic        id_uses_hilo;
    logic        ex_flush;
    logic [1:0]  ex_wb;
    logic [1:0]  ex_m;
    logic [13:0] ex_ex;
    logic [4:0]  ex_rt;
    logic        ex_valid;
    logic        pc_write;
    logic        ifid_write;
    logic        stall;
    logic        md_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic [15:0] snap;
`endif

    logic [23:0] sb[$];
    logic [23:0] got;
    logic [23:0] exp_v;
    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl_pipe #(
        .WB_W(2), .M_W(2), .EX_W(14), .MEMREAD_BIT(1), .REG_AW(5), .MD_LAT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_md(id_is_md), .id_uses_hilo(id_uses_hilo), .ex_flush(ex_flush),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex), .ex_rt(ex_rt), .ex_valid(ex_valid),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input logic [1:0] wb, input logic [1:0] m,
                                       input logic [13:0] ex, input logic [4:0] rt, input logic v);
        pk = {wb, m, ex, rt, v};
    endfunction

    task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [13:0] ex,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic md, input logic hilo, input logic fl);
        id_wb = wb; id_m = m; id_ex = ex; id_valid = v; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; id_is_md = md; id_uses_hilo = hilo; ex_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 14'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid};
        n_chk++; if (got !== 24'h0) begin n_fail++; $display("FAIL rst_ex got=%h exp=%h", got, 24'h0); end
        n_chk++; if ({stall, pc_write, ifid_write, md_busy} !== 4'b0110) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=0110", {stall, pc_write, ifid_write, md_busy}); end
        reset = 1'b0;
        sb.push_back(24'h0);
        tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rst_idle_ex got=%h exp=%h", got, exp_v); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_idle_stall got=%b exp=0", stall); end
    endtask

    task automatic test_load_use();
        drive(2'b11, 2'b10, 14'h0123, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall got=%b exp=0", stall); end
        sb.push_back(pk(2'b11, 2'b10, 14'h0123, 5'd5, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL lu_lw_ex got=%h exp=%h", got, exp_v); end
        drive(2'b10, 2'b00, 14'h0456, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        n_chk++; if ({stall, pc_write, ifid_write} !== 3'b100) begin n_fail++; $display("FAIL lu_stall got=%b exp=100", {stall, pc_write, ifid_write}); end
        sb.push_back(24'h0); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL lu_bubble got=%h exp=%h", got, exp_v); end
        n_chk++; if ({stall, pc_write} !== 2'b01) begin n_fail++; $display("FAIL lu_release got=%b exp=01", {stall, pc_write}); end
        sb.push_back(pk(2'b10, 2'b00, 14'h0456, 5'd6, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL lu_add_ex got=%h exp=%h", got, exp_v); end
        // load into $0 never creates a hazard
        drive(2'b11, 2'b10, 14'h0123, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        sb.push_back(pk(2'b11, 2'b10, 14'h0123, 5'd0, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL lu_lw0_ex got=%h exp=%h", got, exp_v); end
        drive(2'b10, 2'b00, 14'h0456, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        n_chk++; if ({stall, pc_write} !== 2'b01) begin n_fail++; $display("FAIL lu_r0_stall got=%b exp=01", {stall, pc_write}); end
        sb.push_back(pk(2'b10, 2'b00, 14'h0456, 5'd0, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL lu_r0_ex got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_uses_rt();
        for (int u = 0; u < 2; u++) begin
            drive(2'b11, 2'b10, 14'h0077, 1'b1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #1;
            sb.push_back(pk(2'b11, 2'b10, 14'h0077, 5'd5, 1'b1)); tick();
            got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
            n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rt_lw_ex[%0d] got=%h exp=%h", u, got, exp_v); end
            drive(2'b10, 2'b00, 14'h0111, 1'b1, 5'd3, 5'd5, u[0], 1'b0, 1'b0, 1'b0); #1;
            n_chk++; if (stall !== u[0]) begin n_fail++; $display("FAIL rt_stall[%0d] got=%b exp=%b", u, stall, u[0]); end
            if (u == 1) begin
                sb.push_back(24'h0); tick();
                got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
                n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rt_bubble got=%h exp=%h", got, exp_v); end
            end
            sb.push_back(pk(2'b10, 2'b00, 14'h0111, 5'd5, 1'b1)); tick();
            got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
            n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rt_add_ex[%0d] got=%h exp=%h", u, got, exp_v); end
        end
    endtask

    task automatic test_md();
        drive(2'b00, 2'b00, 14'h0200, 1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        n_chk++; if ({stall, md_busy} !== 2'b00) begin n_fail++; $display("FAIL md_issue got=%b exp=00", {stall, md_busy}); end
        sb.push_back(pk(2'b00, 2'b00, 14'h0200, 5'd9, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL md_mult_ex got=%h exp=%h", got, exp_v); end
`ifdef HAZARD_STATS_EN
        snap = stall_cycles;
`endif
        drive(2'b10, 2'b00, 14'h0300, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if ({stall, md_busy, pc_write} !== 3'b110) begin n_fail++; $display("FAIL md_stall[%0d] got=%b exp=110", i, {stall, md_busy, pc_write}); end
            sb.push_back(24'h0); @(posedge clk);
            #1;
            got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
            n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL md_bubble[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        n_chk++; if ({stall, md_busy} !== 2'b00) begin n_fail++; $display("FAIL md_done got=%b exp=00", {stall, md_busy}); end
`ifdef HAZARD_STATS_EN
        n_chk++; if (stall_cycles !== snap + 16'd3) begin n_fail++; $display("FAIL md_stat_stalls got=%0d exp=%0d", stall_cycles, snap + 16'd3); end
`endif
        sb.push_back(pk(2'b10, 2'b00, 14'h0300, 5'd0, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL md_mfhi_ex got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_flush();
        drive(2'b11, 2'b10, 14'h0123, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        sb.push_back(pk(2'b11, 2'b10, 14'h0123, 5'd5, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL fl_lw_ex got=%h exp=%h", got, exp_v); end
`ifdef HAZARD_STATS_EN
        snap = flush_count;
`endif
        drive(2'b10, 2'b00, 14'h0456, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        n_chk++; if ({stall, pc_write, ifid_write} !== 3'b011) begin n_fail++; $display("FAIL fl_prio got=%b exp=011", {stall, pc_write, ifid_write}); end
        sb.push_back(24'h0); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL fl_bubble got=%h exp=%h", got, exp_v); end
`ifdef HAZARD_STATS_EN
        n_chk++; if (flush_count !== snap + 16'd1) begin n_fail++; $display("FAIL fl_stat got=%0d exp=%0d", flush_count, snap + 16'd1); end
`endif
        // a flush does not cancel an issued mult/div
        drive(2'b00, 2'b00, 14'h0200, 1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        sb.push_back(pk(2'b00, 2'b00, 14'h0200, 5'd9, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL fl_mult_ex got=%h exp=%h", got, exp_v); end
        drive(2'b10, 2'b00, 14'h0300, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        n_chk++; if ({stall, md_busy} !== 2'b01) begin n_fail++; $display("FAIL fl_md_prio got=%b exp=01", {stall, md_busy}); end
        sb.push_back(24'h0); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL fl_md_bubble got=%h exp=%h", got, exp_v); end
        n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL fl_md_keep got=%b exp=1", md_busy); end
        drive(2'b00, 2'b00, 14'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL fl_md_drain got=%b exp=0", md_busy); end
    endtask

    task automatic test_reset_mid();
        drive(2'b00, 2'b00, 14'h0200, 1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        sb.push_back(pk(2'b00, 2'b00, 14'h0200, 5'd9, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rm_mult_ex got=%h exp=%h", got, exp_v); end
        drive(2'b10, 2'b00, 14'h0456, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        sb.push_back(pk(2'b10, 2'b00, 14'h0456, 5'd2, 1'b1)); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rm_add_ex got=%h exp=%h", got, exp_v); end
        n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_pre got=%b exp=1", md_busy); end
        #2 reset = 1'b1;
        #1;
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid};
        n_chk++; if (got !== 24'h0) begin n_fail++; $display("FAIL rm_ex_clear got=%h exp=%h", got, 24'h0); end
        n_chk++; if ({md_busy, stall, pc_write, ifid_write} !== 4'b0011) begin n_fail++; $display("FAIL rm_ctrl got=%b exp=0011", {md_busy, stall, pc_write, ifid_write}); end
`ifdef HAZARD_STATS_EN
        n_chk++; if ({stall_cycles, flush_count} !== 32'h0) begin n_fail++; $display("FAIL rm_stats got=%h exp=0", {stall_cycles, flush_count}); end
`endif
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 2'b00, 14'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.push_back(24'h0); tick();
        got = {ex_wb, ex_m, ex_ex, ex_rt, ex_valid}; exp_v = sb.pop_front();
        n_chk++; if (got !== exp_v) begin n_fail++; $display("FAIL rm_after_ex got=%h exp=%h", got, exp_v); end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_uses_rt();
        test_md();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
